div_arbiter: RTL and testbench

DIV_ARBITER -- requirements
Module: div_arbiter

---
 rtl/div_pkg.sv | 15 +
 rtl/rr_picker.sv | 29 ++
 rtl/div_arbiter.sv | 138 +++++++++++++
 tb/tb_div_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared defaults and FSM encoding for the divider arbiter.
package div_pkg;

  localparam int WIDTH_DEF   = 4;
  localparam int NUM_REQ_DEF = 4;
  localparam int TIMEOUT_DEF = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: first requester after the last-served index.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      idx
);

  always_comb begin
    logic found;
    int   c;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    c     = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      c = (int'(last) + k) % NUM_REQ;
      if (!found && req[c]) begin
        found    = 1'b1;
        grant[c] = 1'b1;
        idx      = IW'(c);
      end
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// Arbitrates several requesters onto one shared slow divider,
// with zero-divisor short-circuit and WAIT timeout.
module div_arbiter
  import div_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_nr,
  input  logic [NUM_REQ*WIDTH-1:0] req_dr,
  output logic [NUM_REQ-1:0]       ack,
  output logic [WIDTH-1:0]         q,
  output logic [WIDTH-1:0]         r,
  output logic                     err,
  output logic                     busy,
  output logic                     div_start,
  output logic [WIDTH-1:0]         div_nr,
  output logic [WIDTH-1:0]         div_dr,
  input  logic                     div_done,
  input  logic [WIDTH-1:0]         div_q,
  input  logic [WIDTH-1:0]         div_r
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  state_t             state, state_nxt;
  logic [IW-1:0]      last, gidx, pick_idx;
  logic [NUM_REQ-1:0] pick_grant, grant_oh;
  logic [WIDTH-1:0]   nr, dr, q_res, r_res;
  logic [WIDTH-1:0]   sel_nr, sel_dr;
  logic               err_res;
  logic [CW-1:0]      cnt;
  logic               any_req, expired;

  rr_picker #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
    .req   (req),
    .last  (last),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  assign any_req = |req;
  assign sel_nr  = req_nr[int'(pick_idx)*WIDTH +: WIDTH];
  assign sel_dr  = req_dr[int'(pick_idx)*WIDTH +: WIDTH];
  assign expired = (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (any_req)
          state_nxt = (sel_dr != '0) ? ISSUE : RESP;
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (div_done || expired)
          state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operands and results are latched so req churn cannot disturb them.
  always_ff @(posedge clk) begin
    if (reset) begin
      last     <= IW'(NUM_REQ - 1);
      gidx     <= '0;
      grant_oh <= '0;
      nr       <= '0;
      dr       <= '0;
      q_res    <= '0;
      r_res    <= '0;
      err_res  <= 1'b0;
      cnt      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            gidx     <= pick_idx;
            grant_oh <= pick_grant;
            nr       <= sel_nr;
            dr       <= sel_dr;
            cnt      <= '0;
            if (sel_dr == '0) begin
              q_res   <= '1;
              r_res   <= sel_nr;
              err_res <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (div_done) begin
            q_res   <= div_q;
            r_res   <= div_r;
            err_res <= 1'b0;
          end else if (expired) begin
            q_res   <= '0;
            r_res   <= '0;
            err_res <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP:    last <= gidx;
        default: ;
      endcase
    end
  end

  always_comb begin
    ack       = '0;
    q         = '0;
    r         = '0;
    err       = 1'b0;
    busy      = (state != IDLE);
    div_start = (state == ISSUE);
    div_nr    = nr;
    div_dr    = dr;
    if (state == RESP) begin
      ack = grant_oh;
      q   = q_res;
      r   = r_res;
      err = err_res;
    end
  end

endmodule

// File: tb/tb_div_arbiter.sv
// Scoreboard bench for div_arbiter with a behavioural slow divider.
module tb_div_arbiter;

  localparam int W   = 4;
  localparam int N   = 4;
  localparam int TO  = 64;
  localparam int DLY = 3;

  typedef struct {
    int         idx;
    logic [3:0] q;
    logic [3:0] r;
    logic       err;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] req;
  logic [N*W-1:0] req_nr, req_dr;
  logic [N-1:0] ack;
  logic [W-1:0] q, r;
  logic         err, busy, div_start;
  logic [W-1:0] div_nr, div_dr;
  logic         div_done;
  logic [W-1:0] div_q, div_r;

  exp_t sb[$];
  int   rem[N];
  int   vecs = 0;
  int   errs = 0;
  int   start_cnt = 0;
  logic stub = 1'b0;
  int   dcnt;
  logic [W-1:0] lat_n, lat_d;

  always #5 clk = ~clk;

  div_arbiter #(.WIDTH(W), .NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_nr    (req_nr),
    .req_dr    (req_dr),
    .ack       (ack),
    .q         (q),
    .r         (r),
    .err       (err),
    .busy      (busy),
    .div_start (div_start),
    .div_nr    (div_nr),
    .div_dr    (div_dr),
    .div_done  (div_done),
    .div_q     (div_q),
    .div_r     (div_r)
  );

  // Slow divider sharing the arbiter reset; stub mode never finishes.
  always @(posedge clk) begin
    if (reset) begin
      dcnt     <= 0;
      div_done <= 1'b0;
      div_q    <= '0;
      div_r    <= '0;
      lat_n    <= '0;
      lat_d    <= '0;
    end else begin
      div_done <= 1'b0;
      if (div_start) begin
        dcnt  <= DLY;
        lat_n <= div_nr;
        lat_d <= div_dr;
      end else if (dcnt != 0) begin
        dcnt <= dcnt - 1;
        if (dcnt == 1 && !stub && lat_d != 0) begin
          div_done <= 1'b1;
          div_q    <= lat_n / lat_d;
          div_r    <= lat_n % lat_d;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on ack and models requester release.
  always @(negedge clk) begin
    if (div_start) start_cnt++;
    if (ack !== '0) begin
      exp_t e;
      logic [N-1:0] eack;
      vecs++;
      if (sb.size() == 0) begin
        errs++;
        $display("FAIL unexpected_ack ack=%b q=%0d r=%0d err=%b", ack, q, r, err);
      end else begin
        e = sb.pop_front();
        eack = '0;
        eack[e.idx] = 1'b1;
        if (ack !== eack || q !== e.q || r !== e.r || err !== e.err) begin
          errs++;
          $display("FAIL resp ack=%b q=%0d r=%0d err=%b expected ack=%b q=%0d r=%0d err=%b",
                   ack, q, r, err, eack, e.q, e.r, e.err);
        end
      end
      for (int i = 0; i < N; i++) begin
        if (ack[i]) begin
          if (rem[i] > 0) rem[i]--;
          req[i] = (rem[i] > 0);
        end
      end
    end else if (!reset) begin
      vecs++;
      if (q !== '0 || r !== '0 || err !== 1'b0) begin
        errs++;
        $display("FAIL idle_outputs q=%0d r=%0d err=%b expected 0 0 0", q, r, err);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req = '0;
    for (int i = 0; i < N; i++) rem[i] = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic request(input int i, input int nv, input int dv, input int n);
    req_nr[i*W +: W] = W'(nv);
    req_dr[i*W +: W] = W'(dv);
    rem[i] = n;
    req[i] = 1'b1;
  endtask

  task automatic push(input int i, input int qv, input int rv, input logic e);
    exp_t x;
    x.idx = i;
    x.q = W'(qv);
    x.r = W'(rv);
    x.err = e;
    sb.push_back(x);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy || req != '0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    vecs++;
    if (n >= 500) begin
      errs++;
      $display("FAIL %s_drain pending=%0d busy=%b expected 0 0", name, sb.size(), busy);
      sb.delete();
      req = '0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req = '0;
    req_nr = '0;
    req_dr = '0;
    for (int i = 0; i < N; i++) rem[i] = 0;
    repeat (3) @(negedge clk);
    vecs += 6;
    if (ack !== '0) begin errs++; $display("FAIL rst_ack got=%b want 0", ack); end
    if (busy !== 1'b0) begin errs++; $display("FAIL rst_busy got=%b want 0", busy); end
    if (div_start !== 1'b0) begin errs++; $display("FAIL rst_start got=%b want 0", div_start); end
    if (div_nr !== '0) begin errs++; $display("FAIL rst_div_nr got=%0d want 0", div_nr); end
    if (div_dr !== '0) begin errs++; $display("FAIL rst_div_dr got=%0d want 0", div_dr); end
    if ({q, r, err} !== '0) begin errs++; $display("FAIL rst_qrerr got=%0d/%0d/%b want 0", q, r, err); end
    reset = 1'b0;
  endtask

  task automatic test_single();
    @(negedge clk);
    start_cnt = 0;
    request(0, 7, 2, 1);
    push(0, 3, 1, 1'b0);
    @(negedge clk);
    req_nr[3:0] = 4'd15;
    req_dr[3:0] = 4'd1;
    wait_drain("single");
    vecs++;
    if (start_cnt != 1) begin
      errs++;
      $display("FAIL single_starts got=%0d want 1", start_cnt);
    end
  endtask

  task automatic test_pair();
    do_reset();
    request(0, 14, 5, 1);
    request(1, 9, 3, 1);
    push(0, 2, 4, 1'b0);
    push(1, 3, 0, 1'b0);
    wait_drain("pair");
  endtask

  task automatic test_all_four();
    do_reset();
    request(0, 13, 4, 2);
    request(1, 15, 7, 1);
    request(2, 8, 8, 1);
    request(3, 5, 6, 1);
    push(0, 3, 1, 1'b0);
    push(1, 2, 1, 1'b0);
    push(2, 1, 0, 1'b0);
    push(3, 0, 5, 1'b0);
    push(0, 3, 1, 1'b0);
    wait_drain("all_four");
  endtask

  task automatic test_zero_div();
    do_reset();
    start_cnt = 0;
    request(2, 11, 0, 1);
    push(2, 15, 11, 1'b1);
    @(negedge clk);
    vecs++;
    if (ack !== 4'b0100) begin
      errs++;
      $display("FAIL zero_latency ack=%b want 0100", ack);
    end
    wait_drain("zero_div");
    vecs++;
    if (start_cnt != 0) begin
      errs++;
      $display("FAIL zero_starts got=%0d want 0", start_cnt);
    end
  endtask

  task automatic test_timeout();
    int waits, n;
    stub = 1'b1;
    waits = 0;
    n = 0;
    request(1, 10, 3, 1);
    push(1, 0, 0, 1'b1);
    @(negedge clk);
    while (ack === '0 && n < 300) begin
      if (busy && !div_start) waits++;
      @(negedge clk);
      n++;
    end
    wait_drain("timeout");
    vecs++;
    if (waits != TO) begin
      errs++;
      $display("FAIL timeout_waits got=%0d want %0d", waits, TO);
    end
    stub = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n;
    n = 0;
    request(3, 7, 1, 1);
    @(negedge clk);
    while (!(busy && !div_start) && n < 20) begin
      @(negedge clk);
      n++;
    end
    reset = 1'b1;
    @(negedge clk);
    vecs += 3;
    if (busy !== 1'b0 || ack !== '0) begin
      errs++;
      $display("FAIL mid_rst_state busy=%b ack=%b want 0 0", busy, ack);
    end
    if (div_start !== 1'b0 || div_nr !== '0 || div_dr !== '0) begin
      errs++;
      $display("FAIL mid_rst_div start=%b nr=%0d dr=%0d want 0", div_start, div_nr, div_dr);
    end
    if ({q, r, err} !== '0) begin
      errs++;
      $display("FAIL mid_rst_qrerr got=%0d/%0d/%b want 0", q, r, err);
    end
    reset = 1'b0;
    request(0, 6, 4, 1);
    push(0, 1, 2, 1'b0);
    push(3, 7, 0, 1'b0);
    wait_drain("reset_mid");
  endtask

  initial begin
    test_reset();
    test_single();
    test_pair();
    test_all_four();
    test_zero_div();
    test_timeout();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
